// File: rtl/uart_bus_bridge_if.sv
// uart_bus_bridge_if: UART byte-stream and bus-master signal bundle for uart_bus_bridge
// Signals:
//   rx_data/rx_valid        received byte and one-cycle strobe
//   tx_data/tx_valid/tx_ready response byte with valid/ready handshake
//   bus_addr/bus_wdata      single-beat bus address and write data
//   bus_we/bus_re           write/read request, held until bus_ack
//   bus_rdata/bus_ack       slave read data and completion strobe
//   busy/overrun            bridge status
// Modports: master = bridge side, slave = UART/bus environment side.
interface uart_bus_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_we;
    logic              bus_re;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              busy;
    logic              overrun;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_rdata, bus_ack,
        output tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_re, busy, overrun
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_rdata, bus_ack,
        input  tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_re, busy, overrun
    );
endinterface

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART byte-protocol to single-beat bus master bridge for host debug peek/poke
// Frames (MSB first): 'W' addr data -> 'K'; 'R' addr -> data bytes; timeout -> 'E'.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   io   uart_bus_bridge_if.master: rx byte in, tx byte out, bus request/ack, busy, overrun
// Optional feature: define UART_BRIDGE_TIMEOUT_EN to abort a bus request that is not
// acknowledged within TIMEOUT cycles and answer 'E'.
module uart_bus_bridge #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    uart_bus_bridge_if.master io
);
    localparam logic [7:0] CMD_W  = 8'h57;
    localparam logic [7:0] CMD_R  = 8'h52;
    localparam logic [7:0] RSP_K  = 8'h4B;
    localparam logic [7:0] RSP_E  = 8'h45;
    localparam logic [2:0] A_LAST = 3'(ADDR_W / 8 - 1);
    localparam logic [2:0] D_LAST = 3'(DATA_W / 8 - 1);

    if (ADDR_W % 8 != 0 || ADDR_W < 8 || ADDR_W > 32 ||
        DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > 32 || TIMEOUT < 2) begin : g_param_check
        $error("uart_bus_bridge: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t            state, state_nx;
    logic              is_write;
    logic              err;
    logic              expire;
    logic              cmd_byte;
    logic              last_tx;
    logic              ovr;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    assign cmd_byte = io.rx_valid && (io.rx_data == CMD_W || io.rx_data == CMD_R);
    // Write acks and timeout errors are a single byte; reads return DATA_W/8 bytes.
    assign last_tx  = (err || is_write) ? cnt == 3'd0 : cnt == D_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_byte) state_nx = ADDR;
            ADDR:    if (io.rx_valid && cnt == A_LAST) state_nx = is_write ? DATA : BUS;
            DATA:    if (io.rx_valid && cnt == D_LAST) state_nx = BUS;
            BUS:     if (io.bus_ack || expire) state_nx = RESP;
            RESP:    if (io.tx_ready && last_tx) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request strobes and tx valid come straight from the state register, so they
    // rise/fall exactly one edge after the triggering rx byte, ack or acceptance.
    assign io.bus_addr  = addr;
    assign io.bus_wdata = wdata;
    assign io.bus_we    = state == BUS && is_write;
    assign io.bus_re    = state == BUS && !is_write;
    assign io.busy      = state != IDLE;
    assign io.tx_valid  = state == RESP;
    assign io.tx_data   = state != RESP ? 8'h00 : err ? RSP_E : is_write ? RSP_K : rdata[DATA_W-1 -: 8];
    assign io.overrun   = ovr;

    // The byte counter is shared: field position in ADDR/DATA, response byte index in RESP.
    // Read data is shifted left on every accepted byte so the top byte is always next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_write <= 1'b0;
            cnt      <= '0;
            addr     <= '0;
            wdata    <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_byte) begin
                    is_write <= io.rx_data == CMD_W;
                    cnt      <= '0;
                end
                ADDR: if (io.rx_valid) begin
                    addr <= (addr << 8) | ADDR_W'(io.rx_data);
                    cnt  <= cnt == A_LAST ? '0 : cnt + 1'b1;
                end
                DATA: if (io.rx_valid) begin
                    wdata <= (wdata << 8) | DATA_W'(io.rx_data);
                    cnt   <= cnt == D_LAST ? '0 : cnt + 1'b1;
                end
                BUS: if (io.bus_ack && !is_write) rdata <= io.bus_rdata;
                RESP: if (io.tx_ready) begin
                    cnt   <= cnt + 1'b1;
                    rdata <= rdata << 8;
                end
                default: ;
            endcase
        end
    end

    // Bytes arriving while the bus cycle or response is in flight are lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                  ovr <= 1'b0;
        else if (io.rx_valid && (state == BUS || state == RESP)) ovr <= 1'b1;
    end

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt;

    // tcnt counts completed BUS cycles; the request is held exactly TIMEOUT cycles.
    // An ack in the expiry cycle wins over the timeout.
    assign expire = state == BUS && !io.bus_ack && tcnt == TW'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            tcnt <= state == BUS ? tcnt + 1'b1 : '0;
            if (expire)             err <= 1'b1;
            else if (state == IDLE) err <= 1'b0;
        end
    end
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif
endmodule
